// File: rtl/clk_pkg.sv
// Shared definitions for the runtime-reconfigurable clock divider.
// Holds the controller state encoding and the default counter width.
package clk_pkg;

   // Default width of the half-period value and the phase counter
   localparam int DIV_W_DEF = 16;

   // Controller states (plain constants for compatibility with older flows)
   localparam logic [1:0] ST_RUN  = 2'd0;  // dividing, config port open
   localparam logic [1:0] ST_PEND = 2'd1;  // dividing, new value waiting for a boundary
   localparam logic [1:0] ST_STOP = 2'd2;  // clock parked low, config port open

   // The divider counts in both RUN and PEND; any other encoding keeps it parked
   function automatic logic state_counts(input logic [1:0] st);
      return (st == ST_RUN) || (st == ST_PEND);
   endfunction

endpackage

// File: rtl/clk_div_core.sv
// Divider datapath: phase counter, registered divided clock and the
// clk_i-domain enable strobe. It reports the toggle cycle so the controller
// can align reconfiguration with a falling edge of clk_o.
module clk_div_core
   import clk_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [DIV_W-1:0] half_i,
   input  logic             run_i,
   output logic             toggle_o,
   output logic             clk_o,
   output logic             clk_en_o
);

   logic [DIV_W-1:0] ctr_q, ctr_d;
   logic             clk_q, clk_d;
   logic             en_q, en_d;

   // The last cycle of a phase; half_i is never 0 while running
   assign toggle_o = run_i && (ctr_q == (half_i - DIV_W'(1)));

   // Next-state for counter, divided clock and enable strobe
   always_comb begin
      ctr_d = ctr_q;
      clk_d = clk_q;
      en_d  = 1'b0;
      if (!run_i) begin
         // Parked: counter and clock held at zero
         ctr_d = '0;
         clk_d = 1'b0;
      end else if (toggle_o) begin
         // Wrap at half-1 so the counter never runs past its width
         ctr_d = '0;
         clk_d = ~clk_q;
         en_d  = ~clk_q;  // strobe only on the 0->1 toggle
      end else begin
         ctr_d = ctr_q + DIV_W'(1);
      end
   end

   // Register the datapath; reset parks the clock low
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ctr_q <= '0;
         clk_q <= 1'b0;
         en_q  <= 1'b0;
      end else begin
         ctr_q <= ctr_d;
         clk_q <= clk_d;
         en_q  <= en_d;
      end
   end

   assign clk_o    = clk_q;
   assign clk_en_o = en_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Runtime-reconfigurable clock divider controller. clk_o = clk_i / (2*half).
// A new half-period is accepted over a valid/ready port and applied only at a
// falling edge of clk_o, so the output never glitches. half==0 parks clk_o low.
// clk_o is routed onto a global buffer by the instantiating level if needed;
// logic that can stay on clk_i should use clk_en_o instead.
module clk_div_ctrl
   import clk_pkg::*;
#(
   parameter int          DIV_W   = DIV_W_DEF,
   parameter int unsigned DIV_RST = 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             cfg_valid_i,
   input  logic [DIV_W-1:0] cfg_div_i,
   output logic             cfg_ready_o,
   output logic             clk_o,
   output logic             clk_en_o,
   output logic             busy_o
);

   localparam logic [DIV_W-1:0] HALF_RST  = DIV_W'(DIV_RST);
   localparam logic [1:0]       STATE_RST = (DIV_RST != 0) ? ST_RUN : ST_STOP;

   logic [1:0]       state_q, state_d;
   logic [DIV_W-1:0] half_q, half_d;
   logic [DIV_W-1:0] pend_q, pend_d;
   logic             run;
   logic             toggle;
   logic             hs;

   assign cfg_ready_o = (state_q != ST_PEND);
   assign busy_o      = (state_q == ST_PEND);
   assign hs          = cfg_valid_i && cfg_ready_o;
   assign run         = state_counts(state_q);

   clk_div_core #(
      .DIV_W (DIV_W)
   ) u_core (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .half_i   (half_q),
      .run_i    (run),
      .toggle_o (toggle),
      .clk_o    (clk_o),
      .clk_en_o (clk_en_o)
   );

   // Handshake and boundary-aligned application of the new half-period
   always_comb begin
      state_d = state_q;
      half_d  = half_q;
      pend_d  = pend_q;
      case (state_q)
         ST_RUN: begin
            // The acceptance cycle itself still runs on the old half
            if (hs) begin
               pend_d  = cfg_div_i;
               state_d = ST_PEND;
            end
         end
         ST_PEND: begin
            // Falling edge of clk_o: the next low phase uses the new value.
            // For pend==0 the core's own toggle already drives clk_o and ctr to 0.
            if (toggle && clk_o) begin
               if (pend_q != '0) begin
                  half_d  = pend_q;
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            // A zero request while stopped changes nothing
            if (hs && (cfg_div_i != '0)) begin
               half_d  = cfg_div_i;
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
            half_d  = HALF_RST;
         end
      endcase
   end

   // Controller registers; reset discards any pending value
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= STATE_RST;
         half_q  <= HALF_RST;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         half_q  <= half_d;
         pend_q  <= pend_d;
      end
   end

endmodule
